// File: rtl/lut_engine_if.sv
// lut_engine_if: config-stream, lookup-request and result handshakes of lut_engine
// Ports (signals):
//   cfg_start, cfg_valid, cfg_data[CFG_W]: table load stream   (master -> slave)
//   cfg_ready, cfg_done                  : load status          (slave -> master)
//   in_valid, in_addr[N_IN], out_ready   : lookup request/sink  (master -> slave)
//   in_ready, out_valid, out_data[N_CH]  : lookup flow/result   (slave -> master)
interface lut_engine_if #(
  parameter int N_IN = 10,
  parameter int N_CH = 4,
  parameter int CFG_W = 32
);
  logic cfg_start;
  logic cfg_valid;
  logic cfg_ready;
  logic [CFG_W-1:0] cfg_data;
  logic cfg_done;
  logic in_valid;
  logic in_ready;
  logic [N_IN-1:0] in_addr;
  logic out_valid;
  logic out_ready;
  logic [N_CH-1:0] out_data;
  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_addr, out_ready,
    input cfg_ready, cfg_done, in_ready, out_valid, out_data
  );
  modport slave (
    input cfg_start, cfg_valid, cfg_data, in_valid, in_addr, out_ready,
    output cfg_ready, cfg_done, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_engine.sv
// lut_engine: run-time reloadable truth-table evaluator with a registered lookup stage
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   io       lut_engine_if.slave (config stream, lookup request, result)
//   cfg_sum  XOR of beats accepted since last cfg_start/reset (only with LUT_CHECKSUM_EN)
// Table entry a, channel c sits at flat bit a*N_CH + c; beat j fills flat bits j*CFG_W +: CFG_W.
module lut_engine #(
  parameter int N_IN = 10,
  parameter int N_CH = 4,
  parameter int CFG_W = 32
) (
  input logic clk,
  input logic rst_n,
  lut_engine_if.slave io
`ifdef LUT_CHECKSUM_EN
  ,
  output logic [CFG_W-1:0] cfg_sum
`endif
);
  localparam int TB = N_CH * (2 ** N_IN);
  localparam int NB = TB / CFG_W;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  if (TB % CFG_W != 0) begin : g_bad_cfg_w
    $error("lut_engine: table size must be a multiple of CFG_W");
  end
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TB-1:0] mem;
  logic beat, take;
  always_comb begin
    io.cfg_ready = state == LOADING && !io.cfg_start;
    io.cfg_done = state == READY;
    io.in_ready = state == READY && !io.cfg_start && (!io.out_valid || io.out_ready);
    beat = io.cfg_valid && state == LOADING && !io.cfg_start;
    take = io.in_valid && io.in_ready;
    nxt = io.cfg_start ? LOADING : (beat && cnt == LAST) ? READY : state;
    cnt_nxt = io.cfg_start ? '0 : beat ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end
  // Storage is deliberately left unreset; it is unusable until a full load completes.
  always_ff @(posedge clk) begin
    if (beat) mem[int'(cnt) * CFG_W +: CFG_W] <= io.cfg_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_data <= '0;
    end else if (take) begin
      io.out_valid <= 1'b1;
      io.out_data <= mem[int'(io.in_addr) * N_CH +: N_CH];
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end
`ifdef LUT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_sum <= '0;
    else if (io.cfg_start) cfg_sum <= '0;
    else if (beat) cfg_sum <= cfg_sum ^ io.cfg_data;
  end
`endif
endmodule

// File: tb/tb_lut_engine.sv
// tb_lut_engine: directed self-checking bench for lut_engine (small and default configurations)
module tb_lut_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lut_engine_if #(.N_IN(3), .N_CH(2), .CFG_W(4)) s ();
  lut_engine_if d ();
`ifdef LUT_CHECKSUM_EN
  logic [3:0] sum_s;
  logic [31:0] sum_d;
`endif
  lut_engine #(.N_IN(3), .N_CH(2), .CFG_W(4)) u_s (
    .clk(clk),
    .rst_n(rst_n),
    .io(s)
`ifdef LUT_CHECKSUM_EN
    ,
    .cfg_sum(sum_s)
`endif
  );
  lut_engine u_d (
    .clk(clk),
    .rst_n(rst_n),
    .io(d)
`ifdef LUT_CHECKSUM_EN
    ,
    .cfg_sum(sum_d)
`endif
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_s();
    s.cfg_start = 1'b1;
    smp();
    chk("start_cfg_ready", s.cfg_ready, 0);
    chk("start_in_ready", s.in_ready, 0);
    cyc();
    s.cfg_start = 1'b0;
  endtask
  task automatic beat_s(input logic [3:0] b);
    s.cfg_valid = 1'b1;
    s.cfg_data = b;
    smp();
    chk("load_cfg_ready", s.cfg_ready, 1);
    chk("load_cfg_done", s.cfg_done, 0);
    chk("load_in_ready", s.in_ready, 0);
    cyc();
    s.cfg_valid = 1'b0;
  endtask
  task automatic look_s(input logic [2:0] a, input logic [1:0] exp);
    s.in_valid = 1'b1;
    s.in_addr = a;
    s.out_ready = 1'b1;
    smp();
    chk("look_in_ready", s.in_ready, 1);
    cyc();
    s.in_valid = 1'b0;
    smp();
    chk("look_out_valid", s.out_valid, 1);
    chk($sformatf("look_data_a%0d", a), s.out_data, exp);
    cyc();
  endtask
  task automatic look_d(input logic [9:0] a, input logic [3:0] exp);
    d.in_valid = 1'b1;
    d.in_addr = a;
    d.out_ready = 1'b1;
    smp();
    chk("d_in_ready", d.in_ready, 1);
    cyc();
    d.in_valid = 1'b0;
    smp();
    chk("d_out_valid", d.out_valid, 1);
    chk($sformatf("d_data_a%0d", a), d.out_data, exp);
    cyc();
  endtask
  initial begin
    {s.cfg_start, s.cfg_valid, s.cfg_data, s.in_valid, s.in_addr, s.out_ready} = '0;
    {d.cfg_start, d.cfg_valid, d.cfg_data, d.in_valid, d.in_addr, d.out_ready} = '0;
    smp();
    chk("rst_cfg_ready", s.cfg_ready, 0);
    chk("rst_cfg_done", s.cfg_done, 0);
    chk("rst_in_ready", s.in_ready, 0);
    chk("rst_out_valid", s.out_valid, 0);
    chk("rst_out_data", s.out_data, 0);
    chk("rst_d_cfg_done", d.cfg_done, 0);
    chk("rst_d_out_data", d.out_data, 0);
`ifdef LUT_CHECKSUM_EN
    chk("rst_sum", sum_s, 0);
`endif
    cyc();
    rst_n = 1'b1;
    s.in_valid = 1'b1;
    s.cfg_valid = 1'b1;
    smp();
    chk("empty_in_ready", s.in_ready, 0);
    chk("empty_cfg_ready", s.cfg_ready, 0);
    cyc();
    smp();
    chk("empty_out_valid", s.out_valid, 0);
    cyc();
    s.in_valid = 1'b0;
    s.cfg_valid = 1'b0;
    start_s();
    beat_s(4'h1);
    beat_s(4'h2);
    beat_s(4'h4);
    beat_s(4'h8);
    smp();
    chk("load_done", s.cfg_done, 1);
`ifdef LUT_CHECKSUM_EN
    chk("sum_load1", sum_s, 4'hF);
`endif
    cyc();
    look_s(3'd0, 2'b01);
    look_s(3'd2, 2'b10);
    look_s(3'd5, 2'b01);
    look_s(3'd7, 2'b10);
    look_s(3'd1, 2'b00);
    s.out_ready = 1'b0;
    s.in_valid = 1'b1;
    s.in_addr = 3'd0;
    smp();
    chk("bp_first_ready", s.in_ready, 1);
    cyc();
    s.in_addr = 3'd2;
    smp();
    chk("bp_blocked1", s.in_ready, 0);
    chk("bp_data1", s.out_data, 2'b01);
    chk("bp_valid1", s.out_valid, 1);
    cyc();
    smp();
    chk("bp_blocked2", s.in_ready, 0);
    chk("bp_hold", s.out_data, 2'b01);
    cyc();
    s.out_ready = 1'b1;
    smp();
    chk("bp_resume_ready", s.in_ready, 1);
    chk("bp_first_out", s.out_data, 2'b01);
    cyc();
    s.in_addr = 3'd5;
    smp();
    chk("bp_second_valid", s.out_valid, 1);
    chk("bp_second_out", s.out_data, 2'b10);
    chk("bp_third_ready", s.in_ready, 1);
    cyc();
    s.in_valid = 1'b0;
    smp();
    chk("bp_third_valid", s.out_valid, 1);
    chk("bp_third_out", s.out_data, 2'b01);
    cyc();
    smp();
    chk("bp_drained", s.out_valid, 0);
    cyc();
    s.out_ready = 1'b0;
    s.in_valid = 1'b1;
    s.in_addr = 3'd7;
    smp();
    chk("pend_accept", s.in_ready, 1);
    cyc();
    s.in_valid = 1'b0;
    s.cfg_start = 1'b1;
    smp();
    chk("pend_start_in_ready", s.in_ready, 0);
    chk("pend_start_data", s.out_data, 2'b10);
    cyc();
    s.cfg_start = 1'b0;
    s.in_valid = 1'b1;
    smp();
    chk("pend_done_drop", s.cfg_done, 0);
    chk("pend_in_ready", s.in_ready, 0);
    chk("pend_valid", s.out_valid, 1);
    chk("pend_data", s.out_data, 2'b10);
`ifdef LUT_CHECKSUM_EN
    chk("sum_cleared", sum_s, 0);
`endif
    cyc();
    s.out_ready = 1'b1;
    smp();
    chk("pend_deliver", s.out_data, 2'b10);
    chk("pend_deliver_in_ready", s.in_ready, 0);
    cyc();
    smp();
    chk("pend_gone", s.out_valid, 0);
    cyc();
    s.in_valid = 1'b0;
    beat_s(4'h0);
    beat_s(4'h0);
    s.cfg_start = 1'b1;
    s.cfg_valid = 1'b1;
    s.cfg_data = 4'hF;
    smp();
    chk("restart_cfg_ready", s.cfg_ready, 0);
    cyc();
    s.cfg_start = 1'b0;
    s.cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) beat_s(4'h0);
    smp();
    chk("reload_done", s.cfg_done, 1);
`ifdef LUT_CHECKSUM_EN
    chk("sum_zero", sum_s, 0);
`endif
    cyc();
    for (int a = 0; a < 8; a++) look_s(3'(a), 2'b00);
    start_s();
    beat_s(4'h3);
    beat_s(4'h5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cfg_ready", s.cfg_ready, 0);
    chk("mid_rst_cfg_done", s.cfg_done, 0);
    chk("mid_rst_in_ready", s.in_ready, 0);
`ifdef LUT_CHECKSUM_EN
    chk("mid_rst_sum", sum_s, 0);
`endif
    cyc();
    rst_n = 1'b1;
    s.cfg_valid = 1'b1;
    smp();
    chk("mid_rst_empty", s.cfg_ready, 0);
    cyc();
    s.cfg_valid = 1'b0;
    d.cfg_start = 1'b1;
    cyc();
    d.cfg_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      d.cfg_valid = 1'b1;
      d.cfg_data = 32'hFFFF_FFFF;
      smp();
      chk("d_cfg_ready", d.cfg_ready, 1);
      chk("d_cfg_done_early", d.cfg_done, 0);
      cyc();
    end
    d.cfg_valid = 1'b0;
    smp();
    chk("d_cfg_done", d.cfg_done, 1);
`ifdef LUT_CHECKSUM_EN
    chk("d_sum", sum_d, 0);
`endif
    cyc();
    look_d(10'd0, 4'hF);
    look_d(10'd1023, 4'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
